// File: rtl/data_bus_ctrl.sv
// ---------------------------------------------------------------------------
// data_bus_ctrl
//   Routes kronos core data-port accesses to the synchronous data RAM or to a
//   small MMIO register block (hex display, LEDs, switches, mtime/mtimecmp
//   timer), generates the registered one-cycle data_ack and the level timer
//   interrupt. Unmapped accesses are acked (reads return 0) so the bus never
//   stalls.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   data_addr         core byte address
//   data_wr_data      core write data
//   data_mask         byte enables (bit i = byte i)
//   data_wr_en        1 = write, 0 = read
//   data_req          request, held by the core until data_ack
//   data_ack          one-cycle acknowledge
//   data_rd_data      read data, valid while data_ack = 1
//   ram_addr          RAM word address (data_addr[RAM_AW+1:2])
//   ram_wr_data       RAM write data (data_wr_data)
//   ram_mask          RAM byte enables (data_mask)
//   ram_wren          RAM write strobe
//   ram_q             RAM read data, one cycle after address capture
//   hex_val           hex-display register
//   led               LED register
//   sw                asynchronous switch inputs
//   timer_interrupt   mtime >= mtimecmp, registered
//
// MMIO map (byte offsets from MMIO_BASE, 32-byte window)
//   0x00 HEX  RW | 0x04 LED RW [7:0] | 0x08 SW RO | 0x0C MTIMECMP RW
//   0x10 MTIME RW | 0x14..0x1C read 0, writes ignored
// ---------------------------------------------------------------------------
module data_bus_ctrl #(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wr_data,
  input  logic [3:0]        data_mask,
  input  logic              data_wr_en,
  input  logic              data_req,
  output logic              data_ack,
  output logic [31:0]       data_rd_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wr_data,
  output logic [3:0]        ram_mask,
  output logic              ram_wren,
  input  logic [31:0]       ram_q,
  output logic [31:0]       hex_val,
  output logic [7:0]        led,
  input  logic [9:0]        sw,
  output logic              timer_interrupt
);

  // 33 bits so the limit stays representable for any RAM_AW up to 30.
  localparam logic [32:0] RAM_LIMIT = 33'd4 << RAM_AW;

  localparam logic [2:0] OFF_HEX   = 3'd0;
  localparam logic [2:0] OFF_LED   = 3'd1;
  localparam logic [2:0] OFF_SW    = 3'd2;
  localparam logic [2:0] OFF_MTCMP = 3'd3;
  localparam logic [2:0] OFF_MTIME = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RAM_WAIT = 2'd1,
    S_RESP     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] rd_q;
  logic [31:0] hex_q, hex_d;
  logic [7:0]  led_q, led_d;
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtcmp_q, mtcmp_d;
  logic        irq_q;
  logic [9:0]  sw_meta_q, sw_sync_q;

  logic        ram_hit, mmio_hit;
  logic [2:0]  mmio_off;
  logic [31:0] mmio_rdata;
  logic        acc_fire;
  logic        mmio_wr;
  logic        rd_from_mmio;
  logic        rd_from_ram;

  // Byte offset within a word is irrelevant for word-wide registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr[1:0];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // ---- address decode and pass-through to the RAM ----
  assign ram_hit     = ({1'b0, data_addr} < RAM_LIMIT);
  assign mmio_hit    = (data_addr[31:5] == MMIO_BASE[31:5]);
  assign mmio_off    = data_addr[4:2];
  assign ram_addr    = data_addr[RAM_AW+1:2];
  assign ram_wr_data = data_wr_data;
  assign ram_mask    = data_mask;

  // Unmapped addresses fall through to 0, which is also the unmapped read value.
  always_comb begin
    mmio_rdata = '0;
    if (mmio_hit) begin
      case (mmio_off)
        OFF_HEX:   mmio_rdata = hex_q;
        OFF_LED:   mmio_rdata = {24'b0, led_q};
        OFF_SW:    mmio_rdata = {22'b0, sw_sync_q};
        OFF_MTCMP: mmio_rdata = mtcmp_q;
        OFF_MTIME: mmio_rdata = mtime_q;
        default:   mmio_rdata = '0;
      endcase
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          if (ram_hit && !data_wr_en) state_d = S_RAM_WAIT;
          else                        state_d = S_RESP;
        end
      end
      S_RAM_WAIT: state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs and strobes ----
  always_comb begin
    acc_fire     = (state_q == S_IDLE) && data_req;
    ram_wren     = acc_fire && data_wr_en && ram_hit;
    mmio_wr      = acc_fire && data_wr_en && mmio_hit;
    rd_from_mmio = acc_fire && !data_wr_en && !ram_hit;
    rd_from_ram  = (state_q == S_RAM_WAIT);
    data_ack     = (state_q == S_RESP);
  end

  // ---- read data register (holds across writes) ----
  always_ff @(posedge clk) begin
    if (rst)               rd_q <= '0;
    else if (rd_from_ram)  rd_q <= ram_q;
    else if (rd_from_mmio) rd_q <= mmio_rdata;
  end

  // ---- MMIO register next state ----
  always_comb begin
    hex_d   = hex_q;
    led_d   = led_q;
    mtcmp_d = mtcmp_q;
    // A bus write to MTIME replaces this cycle's increment.
    mtime_d = mtime_q + 32'd1;
    if (mmio_wr) begin
      case (mmio_off)
        OFF_HEX:   hex_d   = byte_merge(hex_q, data_wr_data, data_mask);
        OFF_LED:   if (data_mask[0]) led_d = data_wr_data[7:0];
        OFF_MTCMP: mtcmp_d = byte_merge(mtcmp_q, data_wr_data, data_mask);
        OFF_MTIME: mtime_d = byte_merge(mtime_q, data_wr_data, data_mask);
        default:   ;
      endcase
    end
  end

  // ---- MMIO registers, timer compare, switch synchronizer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q     <= '0;
      led_q     <= '0;
      mtime_q   <= '0;
      mtcmp_q   <= 32'hFFFF_FFFF;
      irq_q     <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      hex_q     <= hex_d;
      led_q     <= led_d;
      mtime_q   <= mtime_d;
      mtcmp_q   <= mtcmp_d;
      // Compares current register values, so a write shows up one cycle later.
      irq_q     <= (mtime_q >= mtcmp_q);
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign data_rd_data    = rd_q;
  assign hex_val         = hex_q;
  assign led             = led_q;
  assign timer_interrupt = irq_q;

endmodule
